// File: rtl/gamma_corr_mc.sv
// Multi-channel gamma corrector: per-pixel curve lookup through a shared read port,
// self-initialising identity curves, frame-aligned enable and sticky overrun flag.
module gamma_corr_mc #(
  parameter int DW     = 8,
  parameter int CH     = 3,
  parameter int PER_CH = 0,
  localparam int CHW   = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic               clk_vid,
  input  logic               reset,
  input  logic               ce_pix,
  input  logic               gamma_en,
  input  logic               gamma_wr,
  input  logic [CHW-1:0]     gamma_wr_ch,
  input  logic [DW-1:0]      gamma_wr_addr,
  input  logic [DW-1:0]      gamma_value,
  input  logic               HSync,
  input  logic               VSync,
  input  logic               HBlank,
  input  logic               VBlank,
  input  logic [CH*DW-1:0]   RGB_in,
  output logic               HSync_out,
  output logic               VSync_out,
  output logic               HBlank_out,
  output logic               VBlank_out,
  output logic [CH*DW-1:0]   RGB_out,
  output logic               init_busy,
  output logic               overrun
);

  localparam int NC    = (PER_CH != 0) ? CH : 1;
  localparam int DEPTH = NC * (2 ** DW);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_LOOKUP
  } state_t;

  state_t            r_state;
  logic [AW-1:0]     r_initCnt;
  logic              r_initBusy;
  logic              r_enFrame;
  logic              r_overrun;
  logic [CHW-1:0]    r_ch;
  logic [CH-1:0]     r_done;
  logic [DW-1:0]     r_pix [CH];
  logic [DW-1:0]     r_res [CH];
  logic              r_hs;
  logic              r_vs;
  logic              r_hb;
  logic              r_vb;
  logic              r_hsOut;
  logic              r_vsOut;
  logic              r_hbOut;
  logic              r_vbOut;
  logic [CH*DW-1:0]  r_rgbOut;
  logic [DW-1:0]     r_mem [DEPTH];

  logic              w_wrChOk;
  logic              w_wrEn;
  logic [AW-1:0]     w_wrAddr;
  logic [DW-1:0]     w_wrData;
  logic [AW-1:0]     w_rdAddr;

  // Curves are laid out back to back, 2^DW entries each.
  function automatic logic [AW-1:0] memAddr(input int curve, input logic [DW-1:0] entry);
    return AW'(curve * (2 ** DW) + int'(entry));
  endfunction

  assign w_wrChOk = (PER_CH == 0) || (int'(gamma_wr_ch) < CH);
  assign w_rdAddr = memAddr((PER_CH != 0) ? int'(r_ch) : 0, r_pix[r_ch]);

  always_comb begin
    w_wrEn   = 1'b0;
    w_wrAddr = '0;
    w_wrData = '0;
    if (!reset) begin
      if (r_state == S_INIT) begin
        w_wrEn   = 1'b1;
        w_wrAddr = r_initCnt;
        w_wrData = r_initCnt[DW-1:0];
      end else if (gamma_wr && w_wrChOk) begin
        w_wrEn   = 1'b1;
        w_wrAddr = memAddr((PER_CH != 0) ? int'(gamma_wr_ch) : 0, gamma_wr_addr);
        w_wrData = gamma_value;
      end
    end
  end

  always_ff @(posedge clk_vid) begin
    if (w_wrEn) begin
      r_mem[w_wrAddr] <= w_wrData;
    end
  end

  always_ff @(posedge clk_vid) begin
    if (reset) begin
      r_state    <= S_INIT;
      r_initCnt  <= '0;
      r_initBusy <= 1'b1;
      r_enFrame  <= 1'b0;
      r_overrun  <= 1'b0;
      r_ch       <= '0;
      r_done     <= '0;
      r_hs       <= 1'b0;
      r_vs       <= 1'b0;
      r_hb       <= 1'b0;
      r_vb       <= 1'b0;
      r_hsOut    <= 1'b0;
      r_vsOut    <= 1'b0;
      r_hbOut    <= 1'b0;
      r_vbOut    <= 1'b0;
      r_rgbOut   <= '0;
      for (int c = 0; c < CH; c++) begin
        r_pix[c] <= '0;
        r_res[c] <= '0;
      end
    end else begin
      case (r_state)
        S_INIT: begin
          if (r_initCnt == AW'(DEPTH - 1)) begin
            r_state    <= S_IDLE;
            r_initBusy <= 1'b0;
          end else begin
            r_initCnt <= r_initCnt + 1'b1;
          end
        end
        S_LOOKUP: begin
          if (!ce_pix) begin
            r_res[r_ch]  <= r_mem[w_rdAddr];
            r_done[r_ch] <= 1'b1;
            if (r_ch == CHW'(CH - 1)) begin
              r_state <= S_IDLE;
            end else begin
              r_ch <= r_ch + 1'b1;
            end
          end
        end
        default: ;
      endcase

      // A new pixel always wins: outgoing channels not yet looked up fall back to raw.
      if (ce_pix) begin
        if (r_state == S_LOOKUP) begin
          r_overrun <= 1'b1;
        end
        if (VSync && !r_vs) begin
          r_enFrame <= gamma_en;
        end
        for (int c = 0; c < CH; c++) begin
          if (r_initBusy || !r_enFrame || !r_done[c]) begin
            r_rgbOut[(CH-1-c)*DW +: DW] <= r_pix[c];
          end else begin
            r_rgbOut[(CH-1-c)*DW +: DW] <= r_res[c];
          end
          r_pix[c] <= RGB_in[(CH-1-c)*DW +: DW];
        end
        r_hsOut <= r_hs;
        r_vsOut <= r_vs;
        r_hbOut <= r_hb;
        r_vbOut <= r_vb;
        r_hs    <= HSync;
        r_vs    <= VSync;
        r_hb    <= HBlank;
        r_vb    <= VBlank;
        r_done  <= '0;
        if (r_state != S_INIT) begin
          r_state <= S_LOOKUP;
          r_ch    <= '0;
        end
      end
    end
  end

  assign HSync_out  = r_hsOut;
  assign VSync_out  = r_vsOut;
  assign HBlank_out = r_hbOut;
  assign VBlank_out = r_vbOut;
  assign RGB_out    = r_rgbOut;
  assign init_busy  = r_initBusy;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_gamma_corr_mc.sv
// Directed bench for gamma_corr_mc: three instances cover shared, per-channel
// and wide/four-channel configurations.
module tb_gamma_corr_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        rstA, ceA, enA, wrA, hsA, vsA, hbA, vbA;
  logic [1:0]  wrChA;
  logic [7:0]  wrAddrA, valA;
  logic [23:0] rgbA, rgbOA;
  logic        hsOA, vsOA, hbOA, vbOA, busyA, ovrA;

  logic        rstB, ceB, enB, wrB, hsB, vsB, hbB, vbB;
  logic [1:0]  wrChB;
  logic [7:0]  wrAddrB, valB;
  logic [23:0] rgbB, rgbOB;
  logic        hsOB, vsOB, hbOB, vbOB, busyB, ovrB;

  logic        rstC, ceC, enC, wrC, hsC, vsC, hbC, vbC;
  logic [1:0]  wrChC;
  logic [9:0]  wrAddrC, valC;
  logic [39:0] rgbC, rgbOC;
  logic        hsOC, vsOC, hbOC, vbOC, busyC, ovrC;

  gamma_corr_mc #(.DW(8), .CH(3), .PER_CH(0)) dutA (
    .clk_vid(clk), .reset(rstA), .ce_pix(ceA), .gamma_en(enA), .gamma_wr(wrA),
    .gamma_wr_ch(wrChA), .gamma_wr_addr(wrAddrA), .gamma_value(valA),
    .HSync(hsA), .VSync(vsA), .HBlank(hbA), .VBlank(vbA), .RGB_in(rgbA),
    .HSync_out(hsOA), .VSync_out(vsOA), .HBlank_out(hbOA), .VBlank_out(vbOA),
    .RGB_out(rgbOA), .init_busy(busyA), .overrun(ovrA)
  );

  gamma_corr_mc #(.DW(8), .CH(3), .PER_CH(1)) dutB (
    .clk_vid(clk), .reset(rstB), .ce_pix(ceB), .gamma_en(enB), .gamma_wr(wrB),
    .gamma_wr_ch(wrChB), .gamma_wr_addr(wrAddrB), .gamma_value(valB),
    .HSync(hsB), .VSync(vsB), .HBlank(hbB), .VBlank(vbB), .RGB_in(rgbB),
    .HSync_out(hsOB), .VSync_out(vsOB), .HBlank_out(hbOB), .VBlank_out(vbOB),
    .RGB_out(rgbOB), .init_busy(busyB), .overrun(ovrB)
  );

  gamma_corr_mc #(.DW(10), .CH(4), .PER_CH(1)) dutC (
    .clk_vid(clk), .reset(rstC), .ce_pix(ceC), .gamma_en(enC), .gamma_wr(wrC),
    .gamma_wr_ch(wrChC), .gamma_wr_addr(wrAddrC), .gamma_value(valC),
    .HSync(hsC), .VSync(vsC), .HBlank(hbC), .VBlank(vbC), .RGB_in(rgbC),
    .HSync_out(hsOC), .VSync_out(vsOC), .HBlank_out(hbOC), .VBlank_out(vbOC),
    .RGB_out(rgbOC), .init_busy(busyC), .overrun(ovrC)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Called at a falling edge; issues one ce_pix and returns 'gap' clocks later.
  task automatic applyStimulus(input int dut, input logic [63:0] rgb, input logic vs,
                               input logic hs, input logic hb, input logic vb, input int gap);
    case (dut)
      0: begin rgbA = rgb[23:0]; vsA = vs; hsA = hs; hbA = hb; vbA = vb; ceA = 1'b1; end
      1: begin rgbB = rgb[23:0]; vsB = vs; hsB = hs; hbB = hb; vbB = vb; ceB = 1'b1; end
      default: begin rgbC = rgb[39:0]; vsC = vs; hsC = hs; hbC = hb; vbC = vb; ceC = 1'b1; end
    endcase
    @(negedge clk);
    ceA = 1'b0;
    ceB = 1'b0;
    ceC = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic writeEntry(input int dut, input int ch, input int addr, input int val);
    case (dut)
      0: begin wrA = 1'b1; wrChA = 2'(ch); wrAddrA = 8'(addr); valA = 8'(val); end
      1: begin wrB = 1'b1; wrChB = 2'(ch); wrAddrB = 8'(addr); valB = 8'(val); end
      default: begin wrC = 1'b1; wrChC = 2'(ch); wrAddrC = 10'(addr); valC = 10'(val); end
    endcase
    @(negedge clk);
    wrA = 1'b0;
    wrB = 1'b0;
    wrC = 1'b0;
  endtask

  initial begin
    int n;
    rstA = 1'b1; ceA = 1'b0; enA = 1'b0; wrA = 1'b0; wrChA = '0; wrAddrA = '0; valA = '0;
    hsA = 1'b0; vsA = 1'b0; hbA = 1'b0; vbA = 1'b0; rgbA = '0;
    rstB = 1'b1; ceB = 1'b0; enB = 1'b0; wrB = 1'b0; wrChB = '0; wrAddrB = '0; valB = '0;
    hsB = 1'b0; vsB = 1'b0; hbB = 1'b0; vbB = 1'b0; rgbB = '0;
    rstC = 1'b1; ceC = 1'b0; enC = 1'b0; wrC = 1'b0; wrChC = '0; wrAddrC = '0; valC = '0;
    hsC = 1'b0; vsC = 1'b0; hbC = 1'b0; vbC = 1'b0; rgbC = '0;

    repeat (3) @(negedge clk);
    checkOutput("A reset rgb", rgbOA, 0);
    checkOutput("A reset hs", hsOA, 0);
    checkOutput("A reset vs", vsOA, 0);
    checkOutput("A reset hb", hbOA, 0);
    checkOutput("A reset vb", vbOA, 0);
    checkOutput("A reset overrun", ovrA, 0);
    checkOutput("A reset busy", busyA, 1);
    checkOutput("B reset busy", busyB, 1);
    checkOutput("C reset rgb", rgbOC, 0);
    rstA = 1'b0;
    rstB = 1'b0;
    rstC = 1'b0;

    n = 0;
    while (busyA && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("A init cycles", 64'(n), 256);
    @(negedge clk);

    $display("[TB] identity curve after init");
    enA = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 4);
    applyStimulus(0, 0, 1, 0, 0, 0, 4);
    applyStimulus(0, 64'h123456, 1, 0, 0, 0, 4);
    applyStimulus(0, 0, 1, 0, 0, 0, 4);
    checkOutput("A identity", rgbOA, 64'h123456);

    $display("[TB] inverted shared curve, mid-frame enable");
    enA = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 4);
    applyStimulus(0, 0, 1, 0, 0, 0, 4);
    for (int a = 0; a < 256; a++) writeEntry(0, 0, a, 255 - a);
    enA = 1'b1;
    applyStimulus(0, 64'h00FF10, 1, 0, 0, 0, 4);
    applyStimulus(0, 0, 1, 0, 0, 0, 4);
    checkOutput("A raw mid-frame", rgbOA, 64'h00FF10);
    applyStimulus(0, 0, 0, 0, 0, 0, 4);
    applyStimulus(0, 64'h00FF10, 1, 1, 1, 1, 4);
    applyStimulus(0, 0, 1, 0, 0, 0, 4);
    checkOutput("A inverted", rgbOA, 64'hFF00EF);
    checkOutput("A hs delayed", hsOA, 1);
    checkOutput("A hb delayed", hbOA, 1);
    checkOutput("A vs delayed", vsOA, 1);
    checkOutput("A vb delayed", vbOA, 1);
    applyStimulus(0, 0, 1, 0, 0, 0, 4);
    checkOutput("A hs next", hsOA, 0);
    checkOutput("A hb next", hbOA, 0);
    checkOutput("A zero inverted", rgbOA, 64'hFFFFFF);
    checkOutput("A no overrun", ovrA, 0);

    $display("[TB] overrun with two-clock spacing");
    applyStimulus(0, 64'h102030, 1, 0, 0, 0, 2);
    applyStimulus(0, 64'h405060, 1, 0, 0, 0, 2);
    checkOutput("A overrun set", ovrA, 1);
    checkOutput("A overrun partial", rgbOA, 64'hEF2030);
    applyStimulus(0, 0, 1, 0, 0, 0, 4);
    checkOutput("A overrun partial 2", rgbOA, 64'hBF5060);
    checkOutput("A overrun sticky", ovrA, 1);

    $display("[TB] per-channel curves");
    n = 0;
    while (busyB && n < 20000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("B init done", busyB, 0);
    enB = 1'b1;
    for (int a = 0; a < 256; a++) writeEntry(1, 0, a, 255 - a);
    for (int a = 0; a < 256; a++) writeEntry(1, 2, a, 8'h80);
    writeEntry(1, 3, 8'h20, 8'h55);
    writeEntry(1, 3, 8'h10, 8'h55);
    applyStimulus(1, 0, 0, 0, 0, 0, 4);
    applyStimulus(1, 64'h102030, 1, 0, 0, 0, 4);
    applyStimulus(1, 0, 1, 0, 0, 0, 4);
    checkOutput("B per-channel", rgbOB, 64'hEF2080);
    applyStimulus(1, 0, 1, 0, 0, 0, 4);
    checkOutput("B per-channel zero", rgbOB, 64'hFF0080);

    $display("[TB] DW=10 CH=4 halving curve");
    n = 0;
    while (busyC && n < 20000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("C init done", busyC, 0);
    for (int c = 0; c < 4; c++) begin
      for (int a = 0; a < 1024; a++) writeEntry(2, c, a, a >> 1);
    end
    enC = 1'b1;
    applyStimulus(2, 0, 0, 0, 0, 0, 5);
    applyStimulus(2, 64'hFF_FFFF_FFFF, 1, 0, 0, 0, 5);
    applyStimulus(2, 64'hFF_C008_0001, 1, 0, 0, 0, 5);
    checkOutput("C halve max", rgbOC, 64'h7F_DFF7_FDFF);
    applyStimulus(2, 0, 1, 0, 0, 0, 5);
    checkOutput("C halve mixed", rgbOC, 64'h7F_C004_0000);
    checkOutput("C no overrun", ovrC, 0);

    $display("[TB] reset during init");
    rstA = 1'b1;
    @(negedge clk);
    rstA = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    checkOutput("A busy at 100", busyA, 1);
    @(negedge clk);
    rstA = 1'b1;
    @(negedge clk);
    rstA = 1'b0;
    checkOutput("A overrun cleared", ovrA, 0);
    n = 0;
    while (busyA && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 200) begin
        wrA = 1'b1; wrChA = 2'd0; wrAddrA = 8'h10; valA = 8'h99;
      end else begin
        wrA = 1'b0;
      end
    end
    wrA = 1'b0;
    checkOutput("A reinit cycles", 64'(n), 256);
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 0, 0, 4);
    applyStimulus(0, 64'h101010, 1, 0, 0, 0, 4);
    applyStimulus(0, 0, 1, 0, 0, 0, 4);
    checkOutput("A busy write dropped", rgbOA, 64'h101010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
